perm_input_loader: RTL and testbench
====================================

Name: perm_input_loader

Overview:
- Upstream feeder for the permutation controller/datapath.
- Collects NUM_WORDS words from a valid/ready stream into a flat state register.
- Once the register is full, pulses the permutation's start input and tracks its ready output until the run finishes.
- Then signals done and re-arms for the next block; state_out drives the permutation's input-load path.

Parameters:
- WORD_W, 64, width of one input word in bits.
- NUM_WORDS, 25, words per permutation state.
- CNT_W, 5, word-counter width; must satisfy 2^CNT_W >= NUM_WORDS.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream word valid.
- in_data  input  WORD_W  upstream word.
- in_ready  output  1  loader can accept a word this cycle.
- flush  input  1  synchronous discard of a partially filled state.
- perm_ready  input  1  permutation idle flag; high while the permutation controller is in Idle.
- perm_start  output  1  one-cycle start pulse to the permutation.
- state_out  output  WORD_W*NUM_WORDS  assembled state; word k occupies bits [k*WORD_W +: WORD_W].
- word_cnt  output  CNT_W  words accepted into the current state.
- busy  output  1  high from START through WAIT_DONE.
- done  output  1  one-cycle pulse when the permutation run completes.

Behaviour:
- Reset (async) values:
  - state = FILL; word_cnt = 0; state_out = 0.
  - perm_start = 0, busy = 0, done = 0.
  - in_ready = 1, since it decodes from FILL.
- States: FILL, START, WAIT_ACK, WAIT_DONE, DONE. Encoded 3-bit, registered, async reset.
- FILL:
  - in_ready = 1.
  - Transfer occurs when in_valid && in_ready. On transfer: state_out word[word_cnt] <= in_data; word_cnt++.
  - If the transfer is word NUM_WORDS-1: word_cnt <= 0, next state = START. Word accepted same cycle, no extra bubble.
  - flush=1 in FILL: word_cnt <= 0 and any transfer that cycle is dropped (flush wins). state_out is not cleared.
  - flush is ignored in every other state.
- START:
  - perm_start = 1 for exactly this cycle; busy = 1; in_ready = 0. Next state = WAIT_ACK unconditionally.
- WAIT_ACK:
  - busy = 1. Stay while perm_ready = 1; go to WAIT_DONE when perm_ready = 0.
  - The permutation leaves Idle one cycle after sampling start, so the minimum stay here is 1 cycle.
- WAIT_DONE:
  - busy = 1. Stay while perm_ready = 0; go to DONE when perm_ready = 1.
- DONE:
  - done = 1 for one cycle; busy = 0; in_ready = 0. Next state = FILL.
- state_out is frozen from START through DONE. Downstream sees it stable for the whole run, including the permutation's Init/putInput cycle.
- in_ready is a pure decode of state; it has no combinational path from in_valid.
- Reset mid-operation:
  - Returns to FILL with word_cnt = 0 and state_out = 0. A partial state is lost.
  - perm_start drops immediately; no done pulse.
- in_valid in non-FILL states: ignored, no transfer. Upstream must hold the word.
- word_cnt wraps only through the NUM_WORDS-1 to 0 transition and never reaches NUM_WORDS.
- Latency: last word accepted at cycle T; perm_start high at T+1; done at (cycle perm_ready returns high) + 1.

Optional Feature:
- Macro: PERM_LOADER_BYTESWAP_EN.
- Defined: each accepted in_data has its byte order reversed before storage (byte 0 ↔ byte WORD_W/8-1). WORD_W must be a multiple of 8.
- Undefined: in_data is stored unmodified.
- Affects only the stored value; handshake timing is identical in both builds.

Test Plan:
- Reset then idle: rst pulse, in_valid=0 → in_ready=1, word_cnt=0, state_out=0, perm_start=0, busy=0, done=0.
- Fill and start (WORD_W=8, NUM_WORDS=4, continuous valid, data 0x11,0x22,0x33,0x44):
  - state_out=0x44332211.
  - perm_start high exactly 1 cycle after the 0x44 transfer.
  - in_ready=0 from that cycle on.
- Full handshake: model perm_ready dropping 1 cycle after start and returning 5 cycles later → busy high for 7 cycles, done single pulse, then in_ready=1 and word_cnt=0.
- Flush: accept 0x11,0x22, then flush=1 with in_valid=1 and data 0x99 → word_cnt=0, 0x99 not counted. Next four words form the state.
- Backpressure and reset: in_valid held high during WAIT_DONE → no transfer, word_cnt stays 0. Then async rst asserted mid-WAIT_DONE → FILL, busy=0, no done pulse.
- Byte swap (macro defined, WORD_W=16): word 0x1234 → stored 0x3412. Undefined build stores 0x1234.

Source files
------------

// File: rtl/perm_input_loader.sv
// perm_input_loader: gathers NUM_WORDS words from a valid/ready stream into a
// flat state register, kicks the permutation with a one-cycle start pulse,
// follows its ready flag until the run completes, then pulses done and re-arms.
// state_out is held stable from START through DONE so the permutation can load
// it at any point during its run.
// Optional build macro: PERM_LOADER_BYTESWAP_EN reverses the byte order of
// each accepted word before it is stored (WORD_W must be a multiple of 8).
module perm_input_loader #(
  parameter int WORD_W    = 64,
  parameter int NUM_WORDS = 25,
  parameter int CNT_W     = 5   // 2**CNT_W must be >= NUM_WORDS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [WORD_W-1:0]           in_data,
  output logic                        in_ready,
  input  logic                        flush,
  input  logic                        perm_ready,
  output logic                        perm_start,
  output logic [WORD_W*NUM_WORDS-1:0] state_out,
  output logic [CNT_W-1:0]            word_cnt,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [2:0] {
    FILL      = 3'd0,
    START     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  state_t            state;
  logic [WORD_W-1:0] word_in;
  logic              take;

`ifdef PERM_LOADER_BYTESWAP_EN
  // Reverse byte order of the incoming word: byte b lands in byte (NB-1-b).
  always_comb begin
    word_in = '0;
    for (int unsigned b = 0; b < WORD_W / 8; b++) begin
      word_in[b*8 +: 8] = in_data[(WORD_W/8 - 1 - b)*8 +: 8];
    end
  end
`else
  // Store incoming words unmodified.
  always_comb begin
    word_in = in_data;
  end
`endif

  // Ready is a pure state decode; flush overrides any handshake in FILL.
  always_comb begin
    in_ready = (state == FILL);
    take     = in_ready && in_valid && !flush;
  end

  // Control FSM with registered start/busy/done, set on entry to each state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      word_cnt   <= '0;
      perm_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          done <= 1'b0;
          if (flush) begin
            word_cnt <= '0;
          end else if (take) begin
            if (word_cnt == LAST_IDX) begin
              word_cnt   <= '0;
              state      <= START;
              perm_start <= 1'b1;
              busy       <= 1'b1;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        START: begin
          perm_start <= 1'b0;
          state      <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!perm_ready) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (perm_ready) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= FILL;
        end
        default: begin
          state      <= FILL;
          word_cnt   <= '0;
          perm_start <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

  // State assembly: write the accepted word into slot word_cnt; only written
  // in FILL, so the contents stay frozen for the whole permutation run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_out <= '0;
    end else if (take) begin
      for (int unsigned k = 0; k < NUM_WORDS; k++) begin
        if (word_cnt == CNT_W'(k)) begin
          state_out[k*WORD_W +: WORD_W] <= word_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_perm_input_loader.sv
// Bench for perm_input_loader: two instances (8-bit and 16-bit words, four
// words per state) share one stimulus stream and are compared every cycle
// against a transaction-level reference of the loader.
module tb_perm_input_loader;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid   = 1'b0;
  logic        flush      = 1'b0;
  logic        perm_ready = 1'b1;
  logic [15:0] in_data    = '0;
  logic [7:0]  in_data8;
  assign in_data8 = in_data[7:0];

  logic        in_ready8, perm_start8, busy8, done8;
  logic [1:0]  word_cnt8;
  logic [31:0] state8;
  logic        in_ready16, perm_start16, busy16, done16;
  logic [1:0]  word_cnt16;
  logic [63:0] state16;

  perm_input_loader #(.WORD_W(8), .NUM_WORDS(N), .CNT_W(2)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data8),
    .in_ready(in_ready8), .flush(flush), .perm_ready(perm_ready),
    .perm_start(perm_start8), .state_out(state8), .word_cnt(word_cnt8),
    .busy(busy8), .done(done8)
  );

  perm_input_loader #(.WORD_W(16), .NUM_WORDS(N), .CNT_W(2)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready16), .flush(flush), .perm_ready(perm_ready),
    .perm_start(perm_start16), .state_out(state16), .word_cnt(word_cnt16),
    .busy(busy16), .done(done16)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [15:0] sw16(input logic [15:0] x);
`ifdef PERM_LOADER_BYTESWAP_EN
    return {x[7:0], x[15:8]};
`else
    return x;
`endif
  endfunction

  // Reference: words accepted so far, and where the current run stands
  // (0 filling, 1 start pulse, 2 awaiting ack, 3 permutation running, 4 done).
  int          m_cnt;
  int          m_phase;
  logic [15:0] m_w [N];
  bit          m_took;
  logic [15:0] dq [$];
  bit          need_new = 1'b1;
  int          p_low, p_delay;
  int          next_l = 5, next_d = 0;
  int          blen = 0;

  task automatic model_reset();
    m_cnt = 0; m_phase = 0; m_took = 1'b0;
    for (int k = 0; k < N; k++) m_w[k] = '0;
  endtask

  task automatic model_edge();
    m_took = 1'b0;
    case (m_phase)
      0: if (flush) m_cnt = 0;
         else if (in_valid) begin
           m_w[m_cnt] = in_data; m_took = 1'b1; m_cnt++;
           if (m_cnt == N) begin m_cnt = 0; m_phase = 1; end
         end
      1: m_phase = 2;
      2: if (!perm_ready) m_phase = 3;
      3: if (perm_ready) m_phase = 4;
      default: m_phase = 0;
    endcase
    if (m_took) begin
      if (dq.size() > 0) void'(dq.pop_front());
      need_new = 1'b1;
    end
  endtask

  task automatic check_all();
    logic [31:0] e8;
    logic [63:0] e16;
    for (int k = 0; k < N; k++) begin
      e8[k*8 +: 8]   = m_w[k][7:0];
      e16[k*16 +: 16] = sw16(m_w[k]);
    end
    chk("in_ready",   64'(in_ready8),   64'(m_phase == 0));
    chk("perm_start", 64'(perm_start8), 64'(m_phase == 1));
    chk("busy",       64'(busy8),       64'(m_phase >= 1 && m_phase <= 3));
    chk("done",       64'(done8),       64'(m_phase == 4));
    chk("word_cnt",   64'(word_cnt8),   64'(m_cnt));
    chk("state8",     64'(state8),      64'(e8));
    chk("state16",    state16,          e16);
    chk("ctrl16", 64'({in_ready16, perm_start16, busy16, done16, word_cnt16}),
                  64'({in_ready8, perm_start8, busy8, done8, word_cnt8}));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    @(negedge clk);
    blen += 32'(busy8);
    check_all();
  endtask

  // Permutation stand-in: idle-high, drops after an optional ack delay,
  // stays low for p_low cycles, then returns to idle.
  task automatic drive_perm();
    case (m_phase)
      0: perm_ready = 1'($urandom_range(0, 1));
      1: begin perm_ready = 1'b1; p_low = next_l; p_delay = next_d; end
      2, 3: begin
        if (p_delay > 0) begin perm_ready = 1'b1; p_delay--; end
        else if (p_low > 0) begin perm_ready = 1'b0; p_low--; end
        else perm_ready = 1'b1;
      end
      default: perm_ready = 1'b1;
    endcase
  endtask

  task automatic step(input bit v, input bit f);
    in_valid = v;
    flush    = f;
    if (dq.size() > 0) in_data = dq[0];
    else if (need_new) begin in_data = 16'($urandom); need_new = 1'b0; end
    drive_perm();
    cycle();
  endtask

  task automatic run_until(input int ph, input int budget);
    int n = 0;
    while (m_phase != ph && n < budget) begin step(1'b1, 1'b0); n++; end
    if (m_phase != ph) chk("timeout", 64'(m_phase), 64'(ph));
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    step(1'b0, 1'b0);

    // Fill with 11,22,33,44 and a 5-cycle permutation run.
    dq = '{16'h1211, 16'h3422, 16'h5633, 16'h7844};
    next_l = 5; next_d = 0; blen = 0;
    run_until(1, 20);
    chk("fill8", 64'(state8), 64'h44332211);
`ifdef PERM_LOADER_BYTESWAP_EN
    chk("fill16", state16, 64'h4478_3356_2234_1112);
`else
    chk("fill16", state16, 64'h7844_5633_3422_1211);
`endif
    run_until(4, 30);
    chk("busy_len", 64'(blen), 64'd7);
    step(1'b0, 1'b0);

    // Flush drops a partial state and the word offered alongside it.
    dq = '{16'h0011, 16'h0022};
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("pre_flush_cnt", 64'(word_cnt8), 64'd2);
    dq = '{16'h0099};
    step(1'b1, 1'b1);
    chk("flush_cnt", 64'(word_cnt8), 64'd0);
    dq.delete();
    dq = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4};
    run_until(1, 20);
    chk("flush_state", 64'(state8), 64'hD4C3B2A1);
    next_d = 2; next_l = 1;
    run_until(0, 30);

    // Byte order of a stored 16-bit word.
    dq = '{16'h1234};
    step(1'b1, 1'b0);
`ifdef PERM_LOADER_BYTESWAP_EN
    chk("swap", 64'(state16[15:0]), 64'h3412);
`else
    chk("swap", 64'(state16[15:0]), 64'h1234);
`endif
    next_l = 8; next_d = 0;
    run_until(3, 30);

    // Backpressure in WAIT_DONE, then asynchronous reset mid-run.
    repeat (3) step(1'b1, 1'b0);
    chk("bp_cnt", 64'(word_cnt8), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",  64'(busy8),     64'd0);
    chk("arst_ready", 64'(in_ready8), 64'd1);
    chk("arst_state", state16,        64'd0);
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    repeat (4) step(1'b0, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      next_l = $urandom_range(1, 6);
      next_d = $urandom_range(0, 2);
      step(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 5));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
